// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchroniser plus stability-count filter
// per key, producing a clean active-high level and one-cycle edge strobes.
module key_debounce #(
    parameter int N_KEYS          = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk100_i,
    input  logic              rstn_i,
    input  logic [N_KEYS-1:0] key_i,
    output logic [N_KEYS-1:0] key_state_o,
    output logic [N_KEYS-1:0] key_press_o,
    output logic [N_KEYS-1:0] key_release_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [N_KEYS-1:0] sample;

    logic [CNT_W-1:0] cnt_q [N_KEYS];
    logic [CNT_W-1:0] cnt_d [N_KEYS];

    logic [N_KEYS-1:0] state_d;
    logic [N_KEYS-1:0] press_d;
    logic [N_KEYS-1:0] release_d;

    // Two-stage synchroniser; idles at 1 because the keys are active-low.
    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key_i;
            sync2 <= sync1;
        end
    end

    assign sample = ~sync2;

    // Filter: count consecutive disagreeing samples, accept on the last one.
    always_comb begin
        state_d   = key_state_o;
        press_d   = '0;
        release_d = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            cnt_d[k] = '0;
            if (sample[k] != key_state_o[k]) begin
                if (cnt_q[k] == CNT_MAX) begin
                    state_d[k]   = sample[k];
                    press_d[k]   = sample[k];
                    release_d[k] = ~sample[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + CNT_ONE;
                end
            end
        end
    end

    // Register counters, debounced level and strobes together.
    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < N_KEYS; k++) begin
                cnt_q[k] <= '0;
            end
            key_state_o   <= '0;
            key_press_o   <= '0;
            key_release_o <= '0;
        end else begin
            for (int k = 0; k < N_KEYS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            key_state_o   <= state_d;
            key_press_o   <= press_d;
            key_release_o <= release_d;
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random key activity,
// compared every cycle against a sample-window reference model.
module tb_key_debounce;

    localparam int NK = 2;
    localparam int DB = 4;

    logic          clk  = 1'b0;
    logic          rstn = 1'b1;
    logic [NK-1:0] key  = '1;
    logic [NK-1:0] state;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;

    int n_checks = 0;
    int n_errors = 0;

    key_debounce #(
        .N_KEYS(NK),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk100_i(clk),
        .rstn_i(rstn),
        .key_i(key),
        .key_state_o(state),
        .key_press_o(press),
        .key_release_o(rel)
    );

    always #10 clk = ~clk;

    // Reference: raw key history per edge since reset. The filter at edge i
    // sees the key value captured two edges earlier (released before that).
    // A level is accepted at edge i when the last DB samples all disagree
    // with the current level and none of them precede the last acceptance.
    logic [NK-1:0] raw_q [$];
    logic [NK-1:0] p_q   [$];
    int            e;
    int            last_chg [NK];
    logic [NK-1:0] m_state, m_press, m_rel;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            raw_q.delete();
            p_q.delete();
            e       = 0;
            m_state = '0;
            m_press = '0;
            m_rel   = '0;
            for (int k = 0; k < NK; k++) last_chg[k] = 0;
        end else begin
            logic [NK-1:0] p;
            e++;
            p = (e >= 3) ? ~raw_q[e-3] : '0;
            raw_q.push_back(key);
            p_q.push_back(p);
            m_press = '0;
            m_rel   = '0;
            for (int k = 0; k < NK; k++) begin
                if (e - last_chg[k] >= DB) begin
                    bit all_diff;
                    all_diff = 1'b1;
                    for (int j = e - DB + 1; j <= e; j++)
                        if (p_q[j-1][k] == m_state[k]) all_diff = 1'b0;
                    if (all_diff) begin
                        m_state[k]  = ~m_state[k];
                        m_press[k]  = m_state[k];
                        m_rel[k]    = ~m_state[k];
                        last_chg[k] = e;
                    end
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("state", 32'(state), 32'(m_state));
            check("press", 32'(press), 32'(m_press));
            check("release", 32'(rel), 32'(m_rel));
            check("excl", 32'(press & rel), 32'd0);
        end
    endtask

    logic [NK-1:0] seen;

    initial begin
        // Reset with keys idle
        #1 rstn = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_press", 32'(press), 32'd0);
        check("rst_rel", 32'(rel), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // 1: idle for 20 cycles, nothing happens
        seen = '0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            seen |= press | rel | state;
        end
        check("idle_quiet", 32'(seen), 32'd0);

        // 2: press key 0, accepted on edge n+5
        key[0] = 1'b0;
        tick(5);
        check("p_early", 32'(state), 32'd0);
        tick(1);
        check("p_state", 32'(state), 32'b01);
        check("p_strobe", 32'(press), 32'b01);
        tick(1);
        check("p_one_cyc", 32'(press), 32'd0);
        tick(3);

        // 4: release key 0, accepted on edge m+5
        key[0] = 1'b1;
        tick(5);
        check("r_early", 32'(state), 32'b01);
        tick(1);
        check("r_state", 32'(state), 32'd0);
        check("r_strobe", 32'(rel), 32'b01);
        tick(1);
        check("r_one_cyc", 32'(rel), 32'd0);
        tick(3);

        // 3: short glitch and repeated 3-low/1-high bursts
        key[0] = 1'b0;
        tick(3);
        key[0] = 1'b1;
        tick(8);
        check("glitch", 32'(state), 32'd0);
        seen = '0;
        for (int i = 0; i < 10; i++) begin
            key[0] = 1'b0;
            for (int j = 0; j < 3; j++) begin
                tick(1);
                seen |= press | rel | state;
            end
            key[0] = 1'b1;
            tick(1);
            seen |= press | rel | state;
        end
        tick(6);
        seen |= press | rel | state;
        check("bursts", 32'(seen), 32'd0);

        // 5: both keys pressed together
        key = 2'b00;
        tick(5);
        check("both_early", 32'(press), 32'd0);
        tick(1);
        check("both_press", 32'(press), 32'b11);
        tick(1);
        check("both_clear", 32'(press), 32'd0);
        check("both_state", 32'(state), 32'b11);
        tick(2);

        // 6: reset while held
        rstn = 1'b0;
        #1;
        check("hr_state", 32'(state), 32'd0);
        check("hr_rel", 32'(rel), 32'd0);
        @(negedge clk);
        check("hr_rel2", 32'(rel), 32'd0);
        rstn = 1'b1;
        tick(5);
        check("hr_early", 32'(press), 32'd0);
        tick(1);
        check("hr_press", 32'(press), 32'b11);
        check("hr_state2", 32'(state), 32'b11);
        tick(2);

        // Random activity with occasional resets
        for (int s = 0; s < 400; s++) begin
            key = NK'($urandom);
            if ($urandom_range(0, 60) == 0) begin
                rstn = 1'b0;
                #1;
                check("rnd_rst", 32'(state | press | rel), 32'd0);
                @(negedge clk);
                rstn = 1'b1;
            end
            tick($urandom_range(1, 8));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
